// File: rtl/ptp_bridge_dbg_pkg.sv
// Shared register map, bit positions and counter indices for the PTP bridge
// TX/RX debug CSR blocks.
package ptp_bridge_dbg_pkg;

  localparam int NUM_CNT = 5;

  // Byte offsets inside the 32-byte debug window
  localparam logic [4:0] OFF_CTRL    = 5'h00;
  localparam logic [4:0] OFF_STATUS  = 5'h04;
  localparam logic [4:0] OFF_TX_PKT  = 5'h08;
  localparam logic [4:0] OFF_TX_PTP  = 5'h0C;
  localparam logic [4:0] OFF_TS_REQ  = 5'h10;
  localparam logic [4:0] OFF_TS_RSP  = 5'h14;
  localparam logic [4:0] OFF_TX_ERR  = 5'h18;
  localparam logic [4:0] OFF_SCRATCH = 5'h1C;

  // CTRL bits
  localparam int CTRL_CNT_EN_BIT = 0;
  localparam int CTRL_SNAP_BIT   = 1;
  localparam int CTRL_CLR_BIT    = 2;

  // STATUS bits
  localparam int STAT_ANY_SAT_BIT  = 0;
  localparam int STAT_SNAP_VLD_BIT = 1;
  localparam int STAT_INST_BIT     = 8;

  // Counter slots, in the same order as their shadow registers in the map
  typedef enum logic [2:0] {
    CNT_TX_PKT = 3'd0,
    CNT_TX_PTP = 3'd1,
    CNT_TS_REQ = 3'd2,
    CNT_TS_RSP = 3'd3,
    CNT_TX_ERR = 3'd4
  } cnt_idx_e;

  // Word index of a byte offset (byte lanes are ignored by the decoder)
  function automatic logic [2:0] reg_idx(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/ptp_bridge_dbg_sat_cnt.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module ptp_bridge_dbg_sat_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic        inc,
  output logic [31:0] cnt,
  output logic        sat
);

  logic [31:0] cnt_q;

  // Clear has priority over a same-cycle increment; saturated value holds
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en && inc && !(&cnt_q)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign cnt = cnt_q;
  assign sat = &cnt_q;

endmodule

// File: rtl/ptp_bridge_tx_dbg_csr.sv
// TX-side debug CSR: live/shadow event counters, control, status and scratch
// behind a one-cycle-latency AVMM read port with no backpressure.
module ptp_bridge_tx_dbg_csr
  import ptp_bridge_dbg_pkg::*;
#(
  parameter int INST_ID    = 0,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   avmm_address_c1,
  input  logic                    avmm_read_c1,
  input  logic                    avmm_write_c1,
  input  logic [DATA_WIDTH-1:0]   avmm_writedata_c1,
  input  logic [DATA_WIDTH/8-1:0] avmm_byteenable_c1,
  output logic [DATA_WIDTH-1:0]   avmm_readdata,
  output logic                    avmm_readdatavalid,
  input  logic                    evt_tx_sop,
  input  logic                    evt_tx_ptp,
  input  logic                    evt_ts_req,
  input  logic                    evt_ts_rsp,
  input  logic                    evt_tx_err
);

  localparam int unsigned INST_U   = INST_ID;
  localparam logic        INST_BIT = INST_U[0];

  localparam logic [2:0] IDX_CTRL    = reg_idx(OFF_CTRL);
  localparam logic [2:0] IDX_STATUS  = reg_idx(OFF_STATUS);
  localparam logic [2:0] IDX_TX_PKT  = reg_idx(OFF_TX_PKT);
  localparam logic [2:0] IDX_TX_PTP  = reg_idx(OFF_TX_PTP);
  localparam logic [2:0] IDX_TS_REQ  = reg_idx(OFF_TS_REQ);
  localparam logic [2:0] IDX_TS_RSP  = reg_idx(OFF_TS_RSP);
  localparam logic [2:0] IDX_TX_ERR  = reg_idx(OFF_TX_ERR);
  localparam logic [2:0] IDX_SCRATCH = reg_idx(OFF_SCRATCH);

  logic                  in_map;
  logic [2:0]            idx;
  logic                  wr_ok;
  logic                  ctrl_wr;
  logic                  addr_lsb_unused;

  logic                  cnt_en;
  logic                  snap_p1;
  logic                  clr_p1;
  logic                  snap_valid;
  logic [DATA_WIDTH-1:0] scratch;

  logic [NUM_CNT-1:0]    evt;
  logic [NUM_CNT-1:0]    sat;
  logic [31:0]           live   [NUM_CNT];
  logic [31:0]           shadow [NUM_CNT];

  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] rd_data_p1;
  logic                  vld_p1;

  assign in_map          = ~|avmm_address_c1[ADDR_WIDTH-1:5];
  assign idx             = avmm_address_c1[4:2];
  assign addr_lsb_unused = ^avmm_address_c1[1:0];
  assign wr_ok           = avmm_write_c1 & in_map;
  assign ctrl_wr         = wr_ok && (idx == IDX_CTRL) && avmm_byteenable_c1[0];

  assign evt[CNT_TX_PKT] = evt_tx_sop;
  assign evt[CNT_TX_PTP] = evt_tx_ptp;
  assign evt[CNT_TS_REQ] = evt_ts_req;
  assign evt[CNT_TS_RSP] = evt_ts_rsp;
  assign evt[CNT_TX_ERR] = evt_tx_err;

  ptp_bridge_dbg_sat_cnt u_cnt_tx_pkt (
    .clk(clk), .rst(rst), .clr(clr_p1), .en(cnt_en), .inc(evt[CNT_TX_PKT]),
    .cnt(live[CNT_TX_PKT]), .sat(sat[CNT_TX_PKT])
  );
  ptp_bridge_dbg_sat_cnt u_cnt_tx_ptp (
    .clk(clk), .rst(rst), .clr(clr_p1), .en(cnt_en), .inc(evt[CNT_TX_PTP]),
    .cnt(live[CNT_TX_PTP]), .sat(sat[CNT_TX_PTP])
  );
  ptp_bridge_dbg_sat_cnt u_cnt_ts_req (
    .clk(clk), .rst(rst), .clr(clr_p1), .en(cnt_en), .inc(evt[CNT_TS_REQ]),
    .cnt(live[CNT_TS_REQ]), .sat(sat[CNT_TS_REQ])
  );
  ptp_bridge_dbg_sat_cnt u_cnt_ts_rsp (
    .clk(clk), .rst(rst), .clr(clr_p1), .en(cnt_en), .inc(evt[CNT_TS_RSP]),
    .cnt(live[CNT_TS_RSP]), .sat(sat[CNT_TS_RSP])
  );
  ptp_bridge_dbg_sat_cnt u_cnt_tx_err (
    .clk(clk), .rst(rst), .clr(clr_p1), .en(cnt_en), .inc(evt[CNT_TX_ERR]),
    .cnt(live[CNT_TX_ERR]), .sat(sat[CNT_TX_ERR])
  );

  // CTRL: enable bit is sticky, snapshot/clear become one-cycle pulses (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_en     <= 1'b0;
      snap_p1    <= 1'b0;
      clr_p1     <= 1'b0;
      snap_valid <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        cnt_en <= avmm_writedata_c1[CTRL_CNT_EN_BIT];
      end
      snap_p1 <= ctrl_wr & avmm_writedata_c1[CTRL_SNAP_BIT];
      clr_p1  <= ctrl_wr & avmm_writedata_c1[CTRL_CLR_BIT];
      if (clr_p1) begin
        snap_valid <= 1'b0;
      end else if (snap_p1) begin
        snap_valid <= 1'b1;
      end
    end
  end

  // Shadows take the pre-increment live values; a coincident clear wins
  always_ff @(posedge clk) begin
    if (rst || clr_p1) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow[i] <= '0;
      end
    end else if (snap_p1) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow[i] <= live[i];
      end
    end
  end

  // SCRATCH with per-byte write enables
  always_ff @(posedge clk) begin
    if (rst) begin
      scratch <= '0;
    end else if (wr_ok && (idx == IDX_SCRATCH)) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (avmm_byteenable_c1[b]) begin
          scratch[8*b +: 8] <= avmm_writedata_c1[8*b +: 8];
        end
      end
    end
  end

  // Read mux sees register values before any same-cycle write lands
  always_comb begin
    rd_mux = '0;
    if (in_map) begin
      case (idx)
        IDX_CTRL:    rd_mux[CTRL_CNT_EN_BIT] = cnt_en;
        IDX_STATUS: begin
          rd_mux[STAT_ANY_SAT_BIT]  = |sat;
          rd_mux[STAT_SNAP_VLD_BIT] = snap_valid;
          rd_mux[STAT_INST_BIT]     = INST_BIT;
        end
        IDX_TX_PKT:  rd_mux = shadow[CNT_TX_PKT];
        IDX_TX_PTP:  rd_mux = shadow[CNT_TX_PTP];
        IDX_TS_REQ:  rd_mux = shadow[CNT_TS_REQ];
        IDX_TS_RSP:  rd_mux = shadow[CNT_TS_RSP];
        IDX_TX_ERR:  rd_mux = shadow[CNT_TX_ERR];
        IDX_SCRATCH: rd_mux = scratch;
        default:     rd_mux = '0;
      endcase
    end
  end

  // ---- stage p1: registered read response ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= avmm_read_c1;
    end
  end

  // Response data register; the output gate below forces zero when idle
  always_ff @(posedge clk) begin
    rd_data_p1 <= rd_mux;
  end

  // A reset landing in the response cycle drops the response
  assign avmm_readdatavalid = vld_p1 & ~rst;
  assign avmm_readdata      = avmm_readdatavalid ? rd_data_p1 : '0;

endmodule

// File: doc/ptp_bridge_tx_dbg_csr.md
PTP_BRIDGE_TX_DBG_CSR -- requirements
Module: ptp_bridge_tx_dbg_csr

Interface
REQ-001 SHALL have parameter INST_ID, default 0: TX instance number (0 = TX_0, 1 = TX_1), reported in STATUS.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: width of the localized (base-subtracted) byte address.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: AVMM data width; only 32 is supported.
REQ-004 SHALL have port clk, input, 1: single clock for all logic.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port avmm_address_c1, input, ADDR_WIDTH: localized byte address from the upstream address-check stage.
REQ-007 SHALL have ports avmm_read_c1 and avmm_write_c1, input, 1 each: already region-qualified strobes.
REQ-008 SHALL have port avmm_writedata_c1, input, 32, and port avmm_byteenable_c1, input, 4.
REQ-009 SHALL have ports avmm_readdata, output, 32, and avmm_readdatavalid, output, 1.
REQ-010 SHALL have ports evt_tx_sop, evt_tx_ptp, evt_ts_req, evt_ts_rsp and evt_tx_err, input, 1 each: single-cycle event pulses.

Function
REQ-011 SHALL decode the register map on avmm_address_c1[4:2], ignoring bits [1:0]:
- 0x00 CTRL, RW: bit0 cnt_en; bit1 snapshot (W1 pulse, reads 0); bit2 clear_all (W1 pulse, reads 0).
- 0x04 STATUS, RO: bit0 any_sat; bit1 snap_valid; bit8 = INST_ID[0].
- 0x08 TX_PKT; 0x0C TX_PTP; 0x10 TS_REQ; 0x14 TS_RSP; 0x18 TX_ERR: RO shadow counters.
- 0x1C SCRATCH, RW.
REQ-012 SHALL return 0 and ignore writes for any address with bits [ADDR_WIDTH-1:5] nonzero.
REQ-013 SHALL assert avmm_readdatavalid exactly one cycle after avmm_read_c1, with avmm_readdata valid in that same cycle; readdata SHALL be 0 whenever readdatavalid is low.
REQ-014 SHALL apply byte enables on CTRL and SCRATCH writes; a CTRL pulse bit acts only if byteenable[0]=1.
REQ-015 SHALL, when read and write are asserted in the same cycle, perform the write and return the pre-write value.
REQ-016 SHALL keep five 32-bit live counters, each incrementing by 1 on its event pulse while cnt_en=1.
REQ-017 SHALL make counters saturate at 0xFFFFFFFF with no wrap; any_sat SHALL be the OR of all live counters at saturation.
REQ-018 SHALL copy all live counters into their shadows on snapshot, one cycle after the write; snap_valid SHALL set then.
REQ-019 SHALL, on clear_all, zero the live counters, shadows and snap_valid one cycle after the write.
REQ-020 SHALL resolve simultaneous events as follows:
- snapshot + clear in one write: shadows capture the pre-clear values, then live counters and snap_valid clear; the snapshot is discarded, so shadows = 0.
- clear + event in the same cycle: the counter becomes 0.
- snapshot + event in the same cycle: the shadow takes the pre-increment value and the live counter increments.
REQ-021 SHALL never let event pulses stall or delay AVMM traffic; the block SHALL have no backpressure.

Reset
REQ-022 SHALL, while rst=1, set:
- avmm_readdatavalid and avmm_readdata to 0;
- CTRL to 0 (cnt_en = 0);
- SCRATCH, all live and shadow counters, and snap_valid to 0.
REQ-023 SHALL drop a read accepted in the cycle before reset asserts (no readdatavalid).
REQ-024 SHALL ignore event pulses during reset.

Structure
REQ-025 SHALL take register offsets, CTRL/STATUS bit positions and a counter-index enum from package ptp_bridge_dbg_pkg, which the RX debug CSR shares.
REQ-026 SHALL instantiate the sub-module ptp_bridge_dbg_sat_cnt (inputs: clk, rst, clr, en, inc; output: cnt[31:0], sat) five times.

Verification
REQ-027 SHALL cover reset then read of every offset: each returns 0 except STATUS bit8 = INST_ID, and readdatavalid is high exactly 1 cycle after each read.
REQ-028 SHALL cover CTRL=1, 10 evt_tx_sop pulses, snapshot, then read 0x08: returns 10; 0x0C returns 0; snap_valid = 1.
REQ-029 SHALL cover SCRATCH write 0xAABBCCDD with byteenable 0xF, then 0x11223344 with byteenable 0x5: a read returns 0xAA22CC44.
REQ-030 SHALL cover a live counter forced to 0xFFFFFFFE plus 3 evt_tx_err pulses, then snapshot: 0x18 reads 0xFFFFFFFF and any_sat = 1; clear_all then returns 0 and any_sat = 0.
REQ-031 SHALL cover CTRL write 0x7 coinciding with an evt_ts_req pulse: TS_REQ shadow and live = 0, snap_valid = 0, cnt_en = 1.
REQ-032 SHALL cover read at address 0x40 and rst asserted in the cycle after a read: both return readdatavalid behaviour per REQ-012 / REQ-023.
